// File: rtl/tm1638_refresh.sv
// TM1638 display refresher: keeps an 8-digit shadow RAM and re-sends the whole
// display (mode, addressed data, display-control frames) whenever it changes.
module tm1638_refresh #(
    parameter logic [2:0] BRIGHT = 3'd7
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clken,
    input  logic       i_wr,
    input  logic [2:0] i_addr,
    input  logic [7:0] i_data,
    output logic       o_tm1638_clk,
    output logic       o_tm1638_stb,
    output logic       o_tm1638_dio,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT_LO,
        S_BIT_HI,
        S_GAP
    } state_t;

    state_t     r_state;
    logic [7:0] r_shadow [8];
    logic       r_dirty;
    logic [1:0] r_frame;
    logic [4:0] r_byte;
    logic [2:0] r_bit;
    logic       r_gap;
    logic [7:0] r_shift;

    logic [4:0] w_last;
    logic [7:0] w_first;
    logic [7:0] w_next;

    // Only F1 carries more than its command byte. The byte following index
    // r_byte is data byte k = r_byte: even k shows a digit, odd k is an LED.
    always_comb begin
        w_last  = (r_frame == 2'd1) ? 5'd16 : 5'd0;
        w_next  = r_byte[0] ? 8'h00 : r_shadow[r_byte[3:1]];
        case (r_frame)
            2'd0:    w_first = 8'h40;
            2'd1:    w_first = 8'hC0;
            default: w_first = {5'b10001, BRIGHT};
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            o_tm1638_clk <= 1'b1;
            o_tm1638_stb <= 1'b1;
            o_tm1638_dio <= 1'b1;
            o_busy       <= 1'b0;
            r_dirty      <= 1'b1;
            r_frame      <= 2'd0;
            r_byte       <= 5'd0;
            r_bit        <= 3'd0;
            r_gap        <= 1'b0;
            r_shift      <= 8'h00;
            for (int i = 0; i < 8; i++) r_shadow[i] <= 8'h00;
        end else begin
            if (i_wr) begin
                r_shadow[i_addr] <= i_data;
                r_dirty          <= 1'b1;
            end
            if (i_clken) begin
                case (r_state)
                    S_IDLE: begin
                        if (r_dirty) begin
                            r_state      <= S_START;
                            o_tm1638_stb <= 1'b0;
                            r_frame      <= 2'd0;
                            o_busy       <= 1'b1;
                        end
                    end
                    S_START: begin
                        r_state      <= S_BIT_LO;
                        o_tm1638_clk <= 1'b0;
                        r_bit        <= 3'd0;
                        r_byte       <= 5'd0;
                        r_shift      <= w_first;
                        o_tm1638_dio <= w_first[0];
                    end
                    S_BIT_LO: begin
                        r_state      <= S_BIT_HI;
                        o_tm1638_clk <= 1'b1;
                    end
                    S_BIT_HI: begin
                        if (r_bit != 3'd7) begin
                            r_state      <= S_BIT_LO;
                            o_tm1638_clk <= 1'b0;
                            r_bit        <= r_bit + 3'd1;
                            o_tm1638_dio <= r_shift[r_bit + 3'd1];
                        end else if (r_byte != w_last) begin
                            // Shadow is sampled here, so late writes still make this refresh.
                            r_state      <= S_BIT_LO;
                            o_tm1638_clk <= 1'b0;
                            r_bit        <= 3'd0;
                            r_byte       <= r_byte + 5'd1;
                            r_shift      <= w_next;
                            o_tm1638_dio <= w_next[0];
                        end else begin
                            r_state      <= S_GAP;
                            o_tm1638_stb <= 1'b1;
                            o_tm1638_dio <= 1'b1;
                            r_gap        <= 1'b0;
                        end
                    end
                    S_GAP: begin
                        if (!r_gap) begin
                            r_gap <= 1'b1;
                        end else if (r_frame == 2'd2) begin
                            r_state <= S_IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            r_state      <= S_START;
                            o_tm1638_stb <= 1'b0;
                            r_frame      <= r_frame + 2'd1;
                            // A coincident write keeps dirty so it gets its own refresh.
                            if (r_frame == 2'd0 && !i_wr) r_dirty <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
